seg7_scan_decoder: RTL and testbench
====================================

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter: STABLE_CYCLES, 4, consecutive identical samples needed to accept a digit; legal range 2..255.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 seg_in  in  7  segment pattern {a,b,c,d,e,f,g}, bit 6 = a, active-high.
REQ-005 dig_sel  in  4  digit strobe, active-high, bit i = digit i; one-hot = digit active, any other value = blanking.
REQ-006 val_out  out  16  captured frame {d3,d2,d1,d0}, 4 bits per digit.
REQ-007 val_valid  out  1  frame available; held until accepted.
REQ-008 val_ready  in  1  consumer accepts val_out when val_valid is also high.
REQ-009 digit_err  out  4  bit i set = digit i pattern not in the legal table for the presented frame.
REQ-010 overrun  out  1  sticky; a completed frame was dropped.

Function
REQ-011 Legal table: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-012 Illegal pattern decodes to nibble 0 and sets that digit's err bit.
REQ-013 Stability counter counts while {seg_in, dig_sel} equals the previous cycle's value and dig_sel is one-hot; it clears on any change or on blanking.
REQ-014 Acceptance occurs in the cycle the counter reaches STABLE_CYCLES-1, once per strobe interval; further matching samples within the same interval are ignored until dig_sel changes.
REQ-015 Collector FSM states: SYNC, COLLECT.
REQ-016 SYNC: wait for acceptance of digit 0; store it, set expected=1, go to COLLECT; acceptance of any other digit is ignored.
REQ-017 COLLECT: acceptance of the expected digit stores it and increments expected.
REQ-018 COLLECT: acceptance of an out-of-order digit discards the partial frame; if it is digit 0, restart with it (stay in COLLECT, expected=1), otherwise go to SYNC.
REQ-019 Acceptance of digit 3 completes the frame: FSM returns to SYNC.
REQ-020 On completion, val_out, digit_err, and val_valid update on the next rising edge, giving 1-cycle latency from digit-3 acceptance.
REQ-021 Transfer occurs when val_valid and val_ready are both high; val_valid clears the next cycle unless a new frame loads simultaneously.
REQ-022 Completion in the same cycle as a transfer: the new frame loads, val_valid stays high, overrun is unaffected.
REQ-023 Completion while val_valid=1 with no transfer: the new frame is dropped, val_out is unchanged, and overrun is set.
REQ-024 val_out and digit_err SHALL be stable while val_valid=1.

Reset
REQ-025 When rst=1 at the clock edge, the following SHALL take effect regardless of any other input: val_out=0, digit_err=0, val_valid=0, overrun=0, FSM=SYNC, stability counter=0, partial frame cleared.
REQ-026 Reset applied mid-frame or while val_valid=1 loses the pending data; there is no recovery.

Configuration
REQ-027 Macro SEG7_SCAN_DP_EN defined: adds input dp_in (1 bit, captured with the digit) and output dp_out (4 bits, per digit, same timing and hold rules as val_out; reset value 0).
REQ-028 Macro absent: no dp ports and no dp storage; all other behaviour is identical.

Structure
REQ-029 Shared package seg7_pkg holds the 16-entry pattern table constants, the collector state enum, and the STABLE_CYCLES default.
REQ-030 Sub-module seg7_pattern_lookup: combinational 7-bit pattern to {nibble, legal}, instantiated once.

Verification
REQ-031 Scan 1111001, 0110000, 1101101, 1001111 on digits 0..3, each held 6 cycles, val_ready=1 -> val_out=16'hE213, digit_err=0, val_valid pulses 1 cycle.
REQ-032 Scan with digit 2 held only 3 cycles (STABLE_CYCLES=4) -> no frame; the next full scan produces a frame.
REQ-033 Digit 1 pattern 1010101 -> val_out[7:4]=0, digit_err=4'b0010.
REQ-034 Order 0,2 -> frame discarded; order 0,1,0,1,2,3 -> exactly one frame.
REQ-035 val_ready=0 for two full frames -> first frame held, overrun=1; val_ready=1 at completion of the second frame -> the second frame loads and overrun=0.
REQ-036 rst pulsed after digit 2 is accepted, then digit 3 -> no frame, all outputs 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seg7 scan decoder.
// Pattern table is {a,b,c,d,e,f,g}, bit 6 = a.
package seg7_pkg;

  localparam int STABLE_CYCLES_DEF = 4;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  typedef enum logic {
    SYNC,
    COLLECT
  } col_state_t;

endpackage

// File: rtl/seg7_pattern_lookup.sv
// Combinational 7-segment pattern to {nibble, legal}.
// Patterns outside the table decode to nibble 0, legal low.
module seg7_pattern_lookup
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       legal
);

  always_comb begin
    nibble = 4'd0;
    legal  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_TABLE[i]) begin
        nibble = 4'(i);
        legal  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Multiplexed 7-seg scan decoder: debounce, frame collect, valid/ready out.
// Define SEG7_SCAN_DP_EN to add the decimal-point input and per-digit output.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
`ifdef SEG7_SCAN_DP_EN
  input  logic        dp_in,
  output logic [3:0]  dp_out,
`endif
  input  logic [6:0]  seg_in,
  input  logic [3:0]  dig_sel,
  output logic [15:0] val_out,
  output logic        val_valid,
  input  logic        val_ready,
  output logic [3:0]  digit_err,
  output logic        overrun
);

  localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);

  logic [6:0] prev_seg;
  logic [3:0] prev_dig;
  logic [7:0] cnt, cnt_nx;
  logic       acc;
  logic       onehot, same;

  assign onehot = (dig_sel != 4'd0) &&
                  ((dig_sel & (dig_sel - 4'd1)) == 4'd0);
  assign same   = (seg_in == prev_seg) && (dig_sel == prev_dig);

  // Saturate at LAST so each strobe interval yields a single accept.
  always_comb begin
    cnt_nx = 8'd0;
    if (same && onehot)
      cnt_nx = (cnt == LAST) ? cnt : cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_seg <= '0;
      prev_dig <= '0;
      cnt      <= '0;
      acc      <= 1'b0;
    end else begin
      prev_seg <= seg_in;
      prev_dig <= dig_sel;
      cnt      <= cnt_nx;
      acc      <= (cnt_nx == LAST) && (cnt != LAST);
    end
  end

  logic [3:0] nib;
  logic       legal;

  seg7_pattern_lookup u_lookup (
    .seg    (prev_seg),
    .nibble (nib),
    .legal  (legal)
  );

  logic [3:0] sel;
  logic [1:0] idx;

  always_comb begin
    sel = acc ? prev_dig : 4'b0001;
    idx = 2'd0;
    unique case (1'b1)
      sel[0]:  idx = 2'd0;
      sel[1]:  idx = 2'd1;
      sel[2]:  idx = 2'd2;
      sel[3]:  idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  col_state_t      state, state_nx;
  logic [1:0]      expd, expd_nx;
  logic [2:0][3:0] part_val, part_val_nx;
  logic [2:0]      part_err, part_err_nx;
  logic            wr, clr, done;
`ifdef SEG7_SCAN_DP_EN
  logic            prev_dp;
  logic [2:0]      part_dp, part_dp_nx;
`endif

  always_comb begin
    state_nx    = state;
    expd_nx     = expd;
    part_val_nx = part_val;
    part_err_nx = part_err;
    wr          = 1'b0;
    clr         = 1'b0;
    done        = 1'b0;
    if (acc) begin
      unique case (state)
        SYNC: begin
          if (idx == 2'd0) begin
            wr       = 1'b1;
            expd_nx  = 2'd1;
            state_nx = COLLECT;
          end
        end
        COLLECT: begin
          if (idx == expd) begin
            if (idx == 2'd3) begin
              done     = 1'b1;
              state_nx = SYNC;
            end else begin
              wr      = 1'b1;
              expd_nx = expd + 2'd1;
            end
          end else if (idx == 2'd0) begin
            clr     = 1'b1;
            wr      = 1'b1;
            expd_nx = 2'd1;
          end else begin
            clr      = 1'b1;
            state_nx = SYNC;
          end
        end
        default: state_nx = SYNC;
      endcase
    end
    if (clr) begin
      part_val_nx = '0;
      part_err_nx = '0;
    end
    if (wr) begin
      part_val_nx[idx] = nib;
      part_err_nx[idx] = ~legal;
    end
  end

`ifdef SEG7_SCAN_DP_EN
  always_comb begin
    part_dp_nx = clr ? 3'd0 : part_dp;
    if (wr)
      part_dp_nx[idx] = prev_dp;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SYNC;
      expd     <= 2'd0;
      part_val <= '0;
      part_err <= '0;
    end else begin
      state    <= state_nx;
      expd     <= expd_nx;
      part_val <= part_val_nx;
      part_err <= part_err_nx;
    end
  end

  // A completed frame only loads when the output slot is free or draining.
  logic load;
  assign load = done && (!val_valid || val_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      val_out   <= '0;
      digit_err <= '0;
      val_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        val_out   <= {nib, part_val};
        digit_err <= {~legal, part_err};
        val_valid <= 1'b1;
      end else if (val_valid && val_ready) begin
        val_valid <= 1'b0;
      end
      if (done && val_valid && !val_ready)
        overrun <= 1'b1;
    end
  end

`ifdef SEG7_SCAN_DP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_dp <= 1'b0;
      part_dp <= '0;
      dp_out  <= '0;
    end else begin
      prev_dp <= dp_in;
      part_dp <= part_dp_nx;
      if (load)
        dp_out <= {prev_dp, part_dp};
    end
  end
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios plus random scan traffic.
// Optional SEG7_SCAN_DP_EN build also checks dp_out.
module tb_seg7_scan_decoder;

  localparam int S = 4;

  localparam logic [6:0] PAT [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  seg_in = '0;
  logic [3:0]  dig_sel = '0;
  logic [15:0] val_out;
  logic        val_valid;
  logic        val_ready = 1'b0;
  logic [3:0]  digit_err;
  logic        overrun;
`ifdef SEG7_SCAN_DP_EN
  logic        dp_in = 1'b0;
  logic [3:0]  dp_out;
`endif

  always #5 clk = ~clk;

  seg7_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef SEG7_SCAN_DP_EN
    .dp_in     (dp_in),
    .dp_out    (dp_out),
`endif
    .seg_in    (seg_in),
    .dig_sel   (dig_sel),
    .val_out   (val_out),
    .val_valid (val_valid),
    .val_ready (val_ready),
    .digit_err (digit_err),
    .overrun   (overrun)
  );

  typedef struct {
    int         d;
    logic [6:0] p;
    logic       dp;
  } acc_t;

  int checks = 0;
  int errors = 0;

  // Reference model: run length of identical one-hot samples, accepted
  // digit history, and the output slot.
  acc_t        hist[$];
  int          run;
  logic [10:0] last_s;
  bit          pend;
  int          pd;
  logic [6:0]  ppat;
  logic        pdp;
  logic [15:0] m_val;
  logic [3:0]  m_err;
  logic [3:0]  m_dp;
  logic        m_valid;
  logic        m_ovr;

  int          vcount;
  logic [15:0] cap_val;
  logic [3:0]  cap_err;
  logic        rdy_g = 1'b0;

  function automatic logic [4:0] dec(input logic [6:0] p);
    dec = 5'd0;
    for (int i = 0; i < 16; i++)
      if (p == PAT[i]) dec = {1'b1, 4'(i)};
  endfunction

  task automatic model_edge();
    logic [4:0]  r;
    logic [15:0] fv;
    logic [3:0]  fe;
    logic [3:0]  fd;
    bit          comp;
    int          n;
    logic [10:0] s;
    bit          oh;
    if (rst) begin
      m_val = 0; m_err = 0; m_dp = 0; m_valid = 0; m_ovr = 0;
      hist.delete();
      pend = 0; run = 0; last_s = 0;
      return;
    end
    comp = 0; fv = 0; fe = 0; fd = 0;
    if (pend) begin
      if (pd == 3) begin
        n = hist.size();
        if (n >= 3 && hist[n-3].d == 0 && hist[n-2].d == 1 &&
            hist[n-1].d == 2) begin
          comp = 1;
          for (int j = 0; j < 3; j++) begin
            r = dec(hist[n-3+j].p);
            fv[j*4 +: 4] = r[3:0];
            fe[j] = ~r[4];
            fd[j] = hist[n-3+j].dp;
          end
          r = dec(ppat);
          fv[15:12] = r[3:0];
          fe[3] = ~r[4];
          fd[3] = pdp;
        end
        hist.delete();
      end else begin
        hist.push_back('{pd, ppat, pdp});
        if (hist.size() > 3) void'(hist.pop_front());
      end
    end
    if (comp) begin
      if (!m_valid || val_ready) begin
        m_val = fv; m_err = fe; m_dp = fd; m_valid = 1;
      end else begin
        m_ovr = 1;
      end
    end else if (m_valid && val_ready) begin
      m_valid = 0;
    end
    s  = {seg_in, dig_sel};
    oh = ($countones(dig_sel) == 1);
    if (oh && s == last_s) run++;
    else run = oh ? 1 : 0;
    last_s = s;
    pend = (run == S);
    pd = 0;
    for (int i = 0; i < 4; i++) if (dig_sel[i]) pd = i;
    ppat = seg_in;
`ifdef SEG7_SCAN_DP_EN
    pdp = dp_in;
`else
    pdp = 1'b0;
`endif
  endtask

  task automatic step(input logic [6:0] s, input logic [3:0] d,
                      input logic p, input logic r, input logic rs);
    @(negedge clk);
    seg_in = s;
    dig_sel = d;
    val_ready = r;
    rst = rs;
`ifdef SEG7_SCAN_DP_EN
    dp_in = p;
`endif
    @(posedge clk);
    model_edge();
    #1;
    if (val_valid) begin
      vcount++;
      cap_val = val_out;
      cap_err = digit_err;
    end
  endtask

  task automatic hold(input int d, input logic [6:0] s, input int n,
                      input logic p);
    repeat (n) step(s, 4'b0001 << d, p, rdy_g, 1'b0);
    step(s, 4'b0000, 1'b0, rdy_g, 1'b0);
  endtask

  task automatic scan(input logic [6:0] p0, input logic [6:0] p1,
                      input logic [6:0] p2, input logic [6:0] p3,
                      input int n);
    hold(0, p0, n, 1'b0);
    hold(1, p1, n, 1'b0);
    hold(2, p2, n, 1'b0);
    hold(3, p3, n, 1'b0);
  endtask

  task automatic do_reset();
    step(7'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    step(7'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    vcount = 0;
  endtask

  task automatic test_reset();
    step(7'h7F, 4'b0001, 1'b1, 1'b1, 1'b1);
    step(7'h7F, 4'b0001, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({val_valid, val_out, digit_err, overrun} !== 22'd0) begin
      errors++;
      $display("FAIL reset: v=%b val=%h err=%b ovr=%b want all 0",
               val_valid, val_out, digit_err, overrun);
    end
`ifdef SEG7_SCAN_DP_EN
    checks++;
    if (dp_out !== 4'd0) begin
      errors++;
      $display("FAIL reset_dp: got %b want 0000", dp_out);
    end
`endif
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    rdy_g = 1'b1;
    hold(0, 7'b1111001, 6, 1'b1);
    hold(1, 7'b0110000, 6, 1'b0);
    hold(2, 7'b1101101, 6, 1'b1);
    hold(3, 7'b1001111, 6, 1'b1);
    checks++;
    if (vcount !== 1) begin
      errors++;
      $display("FAIL basic_pulse: valid cycles %0d want 1", vcount);
    end
    checks++;
    if (cap_val !== 16'hE213 || cap_err !== 4'd0) begin
      errors++;
      $display("FAIL basic_val: got %h/%b want e213/0000", cap_val, cap_err);
    end
    checks++;
    if (val_out !== m_val || val_valid !== m_valid) begin
      errors++;
      $display("FAIL basic_model: got %h/%b want %h/%b",
               val_out, val_valid, m_val, m_valid);
    end
`ifdef SEG7_SCAN_DP_EN
    checks++;
    if (dp_out !== 4'b1101) begin
      errors++;
      $display("FAIL basic_dp: got %b want 1101", dp_out);
    end
`endif
  endtask

  task automatic test_short_hold();
    do_reset();
    rdy_g = 1'b1;
    hold(0, PAT[8], 6, 1'b0);
    hold(1, PAT[9], 6, 1'b0);
    hold(2, PAT[10], S - 1, 1'b0);
    hold(3, PAT[11], 6, 1'b0);
    checks++;
    if (vcount !== 0) begin
      errors++;
      $display("FAIL short_noframe: valid cycles %0d want 0", vcount);
    end
    scan(PAT[8], PAT[9], PAT[10], PAT[11], 6);
    checks++;
    if (vcount !== 1 || cap_val !== 16'hBA98) begin
      errors++;
      $display("FAIL short_next: cycles %0d val %h want 1 ba98",
               vcount, cap_val);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    rdy_g = 1'b1;
    scan(PAT[0], 7'b1010101, PAT[2], PAT[3], 5);
    checks++;
    if (cap_val[7:4] !== 4'd0 || cap_err !== 4'b0010) begin
      errors++;
      $display("FAIL illegal: nib %h err %b want 0 0010",
               cap_val[7:4], cap_err);
    end
    checks++;
    if (vcount !== 1 || cap_val !== m_val || cap_err !== m_err) begin
      errors++;
      $display("FAIL illegal_model: got %h/%b want %h/%b",
               cap_val, cap_err, m_val, m_err);
    end
  endtask

  task automatic test_order();
    do_reset();
    rdy_g = 1'b1;
    hold(0, PAT[1], 5, 1'b0);
    hold(2, PAT[2], 5, 1'b0);
    hold(3, PAT[3], 5, 1'b0);
    checks++;
    if (vcount !== 0) begin
      errors++;
      $display("FAIL order_02: valid cycles %0d want 0", vcount);
    end
    hold(0, PAT[4], 5, 1'b0);
    hold(1, PAT[5], 5, 1'b0);
    hold(0, PAT[6], 5, 1'b0);
    hold(1, PAT[7], 5, 1'b0);
    hold(2, PAT[12], 5, 1'b0);
    hold(3, PAT[13], 5, 1'b0);
    checks++;
    if (vcount !== 1 || cap_val !== 16'hDC76) begin
      errors++;
      $display("FAIL order_restart: cycles %0d val %h want 1 dc76",
               vcount, cap_val);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    rdy_g = 1'b0;
    scan(PAT[0], PAT[1], PAT[2], PAT[3], 6);
    scan(PAT[4], PAT[5], PAT[6], PAT[7], 6);
    checks++;
    if (val_valid !== 1'b1 || val_out !== 16'h3210 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_hold: v=%b val=%h ovr=%b want 1 3210 1",
               val_valid, val_out, overrun);
    end
    rdy_g = 1'b1;
    step(7'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    step(7'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (val_valid !== 1'b0 || overrun !== 1'b1 || val_out !== 16'h3210) begin
      errors++;
      $display("FAIL overrun_sticky: v=%b ovr=%b val=%h want 0 1 3210",
               val_valid, overrun, val_out);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rdy_g = 1'b0;
    scan(PAT[0], PAT[1], PAT[2], PAT[3], 6);
    hold(0, PAT[4], 6, 1'b0);
    hold(1, PAT[5], 6, 1'b0);
    hold(2, PAT[6], 6, 1'b0);
    repeat (S) step(PAT[7], 4'b1000, 1'b0, 1'b0, 1'b0);
    checks++;
    if (val_out !== 16'h3210 || val_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_before: val=%h v=%b want 3210 1", val_out, val_valid);
    end
    step(PAT[7], 4'b1000, 1'b0, 1'b1, 1'b0);
    checks++;
    if (val_out !== 16'h7654 || val_valid !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_load: val=%h v=%b ovr=%b want 7654 1 0",
               val_out, val_valid, overrun);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    rdy_g = 1'b1;
    hold(0, PAT[9], 6, 1'b0);
    hold(1, PAT[9], 6, 1'b0);
    hold(2, PAT[9], 6, 1'b0);
    step(7'd0, 4'd0, 1'b0, 1'b1, 1'b1);
    hold(3, PAT[9], 6, 1'b0);
    checks++;
    if (vcount !== 0 ||
        {val_valid, val_out, digit_err, overrun} !== 22'd0) begin
      errors++;
      $display("FAIL reset_mid: cycles %0d val=%h err=%b ovr=%b want 0",
               vcount, val_out, digit_err, overrun);
    end
  endtask

  task automatic test_random();
    int         pos;
    int         steps;
    int         len;
    logic [3:0] d;
    logic [6:0] s;
    logic       p;
    pos = 0;
    steps = 0;
    do_reset();
    while (steps < 2000) begin
      case ($urandom % 8)
        0: d = 4'($urandom);
        1: d = 4'b0001 << ($urandom % 4);
        default: begin
          d = 4'b0001 << pos;
          pos = (pos + 1) % 4;
        end
      endcase
      s = ($urandom % 8 == 0) ? 7'($urandom) : PAT[$urandom % 16];
      p = 1'($urandom);
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++) begin
        step(s, d, p, 1'($urandom % 3 != 0), 1'($urandom % 300 == 0));
        steps++;
        checks++;
        if ({val_valid, val_out, digit_err, overrun} !==
            {m_valid, m_val, m_err, m_ovr}) begin
          errors++;
          $display("FAIL random@%0d: v=%b val=%h err=%b ovr=%b want v=%b val=%h err=%b ovr=%b",
                   steps, val_valid, val_out, digit_err, overrun,
                   m_valid, m_val, m_err, m_ovr);
        end
`ifdef SEG7_SCAN_DP_EN
        checks++;
        if (dp_out !== m_dp) begin
          errors++;
          $display("FAIL random_dp@%0d: got %b want %b", steps, dp_out, m_dp);
        end
`endif
      end
    end
  endtask

  initial begin
    run = 0; last_s = 0; pend = 0; pd = 0; ppat = 0; pdp = 0;
    m_val = 0; m_err = 0; m_dp = 0; m_valid = 0; m_ovr = 0;
    vcount = 0; cap_val = 0; cap_err = 0;
    test_reset();
    test_basic();
    test_short_hold();
    test_illegal();
    test_order();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
